// File: rtl/mem_byte_copier.sv
// mem_byte_copier: byte-wise memory block copier (read port B/Dob, active-low write port A/Din/WE).
// Optional MEM_COPY_INVERT_EN writes the image negative (8'hFF - byte) instead of a plain copy.
module mem_byte_copier #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              mem_we_n,
    output logic [ADDR_W-1:0] mem_a,
    output logic [ADDR_W-1:0] mem_b,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dob
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] src, dst;
    logic [LEN_W-1:0] cnt, idx, idx_nx;
    logic [7:0] din_nx;
    logic go;

    assign idx_nx = idx + 1'b1;
    assign go = start && (len != '0);
`ifdef MEM_COPY_INVERT_EN
    assign din_nx = 8'hFF - mem_dob;
`else
    assign din_nx = mem_dob;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = !start ? IDLE : (go ? RD : FIN);
            RD:   state_nx = WR;
            WR:   state_nx = (idx_nx == cnt) ? FIN : RD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src <= '0;
            dst <= '0;
            cnt <= '0;
            idx <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            mem_we_n <= 1'b1;
            mem_a <= '0;
            mem_b <= '0;
            mem_din <= '0;
        end else begin
            done <= (state == FIN);
            mem_we_n <= (state != RD);
            case (state)
                IDLE: begin
                    busy <= go;
                    if (go) begin
                        src <= src_base;
                        dst <= dst_base;
                        cnt <= len;
                        idx <= '0;
                        mem_b <= src_base;
                    end
                end
                RD: begin
                    mem_din <= din_nx;
                    mem_a <= dst + ADDR_W'(idx);
                end
                WR: begin
                    idx <= idx_nx;
                    // Next read address is only advanced when another byte follows
                    if (idx_nx != cnt) mem_b <= src + ADDR_W'(idx_nx);
                end
                default: busy <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_byte_copier.sv
// tb_mem_byte_copier: table-driven and randomized checks of mem_byte_copier against a forward byte-copy model.
module tb_mem_byte_copier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_base = '0, dst_base = '0;
    logic [15:0] len = '0;
    logic        busy, done, mem_we_n;
    logic [31:0] mem_a, mem_b;
    logic [7:0]  mem_din, mem_dob;

    mem_byte_copier dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
        .len(len), .busy(busy), .done(done), .mem_we_n(mem_we_n), .mem_a(mem_a),
        .mem_b(mem_b), .mem_din(mem_din), .mem_dob(mem_dob)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load = 1'b0;

    always @(posedge clk) begin
        if (load) mem <= img;
        else if (!mem_we_n) mem[mem_a[7:0]] <= mem_din;
    end
    always @(negedge clk) mem_dob <= mem[mem_b[7:0]];

    int we_cnt = 0, done_cnt = 0, we_pair = 0;
    logic [31:0] rd_log[$];
    bit prev_we = 1'b0;
    always @(negedge clk) begin
        if (!mem_we_n) begin
            we_cnt++;
            rd_log.push_back(mem_b);
            if (prev_we) we_pair++;
        end
        prev_we = !mem_we_n;
        if (done) done_cnt++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] f(input logic [7:0] x);
`ifdef MEM_COPY_INVERT_EN
        return 8'hFF - x;
`else
        return x;
`endif
    endfunction

    task automatic load_mem(input logic [7:0] im [256]);
        img = im;
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n, input int lat,
                       input int intr, input string nm);
        logic [7:0] im [256];
        logic [7:0] rm [256];
        logic [31:0] ta, tb;
        int bw, br, bd, cyc, bad;
        bit seen;
        for (int i = 0; i < 256; i++) im[i] = 8'($urandom);
        im[24] = 8'h11; im[25] = 8'h22; im[26] = 8'h33; im[27] = 8'h44;
        load_mem(im);
        rm = im;
        for (int i = 0; i < n; i++) begin
            ta = d + 32'(i);
            tb = s + 32'(i);
            rm[ta[7:0]] = f(rm[tb[7:0]]);
        end
        bw = we_cnt; br = rd_log.size(); bd = done_cnt;
        @(negedge clk);
        start = 1'b1; src_base = s; dst_base = d; len = 16'(n);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        seen = busy;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (cyc == intr) begin
                start = 1'b1; src_base = '0; dst_base = '0; len = 16'd5;
            end else start = 1'b0;
            seen |= busy;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(lat));
        chk({nm, " busy at done"}, 64'(busy), 64'(0));
        chk({nm, " busy seen"}, 64'(seen), 64'(n != 0));
        repeat (3) @(negedge clk);
        chk({nm, " done pulses"}, 64'(done_cnt - bd), 64'(1));
        chk({nm, " write cycles"}, 64'(we_cnt - bw), 64'(n));
        bad = 0;
        for (int i = 0; i < n && br + i < rd_log.size(); i++)
            if (rd_log[br + i] !== s + 32'(i)) bad++;
        chk({nm, " read addrs bad"}, 64'(bad), 64'(0));
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== rm[i]) bad++;
        chk({nm, " mem bytes bad"}, 64'(bad), 64'(0));
    endtask

    typedef struct {
        logic [31:0] s;
        logic [31:0] d;
        int          n;
        int          lat;
        int          intr;
        string       nm;
    } vec_t;

    initial begin
        vec_t vt [6];
        logic [7:0] im [256];
        logic [31:0] s, d;
        int n;
        vt[0] = '{32'd24, 32'd40, 4, 10, 0, "T2 copy4"};
        vt[1] = '{32'd30, 32'd50, 0, 2, 0, "T3 zero"};
        vt[2] = '{32'd24, 32'd40, 4, 10, 3, "T4 start busy"};
        vt[3] = '{32'hFFFF_FFFF, 32'd100, 2, 6, 0, "T5 wrap"};
        vt[4] = '{32'd60, 32'd59, 8, 18, 0, "T6 overlap"};
        vt[5] = '{32'd80, 32'd80, 3, 8, 0, "src eq dst"};

        repeat (3) @(negedge clk);
        chk("reset we_n", 64'(mem_we_n), 64'(1));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset a/b/din", {mem_a[15:0], mem_b[15:0], mem_din}, 64'(0));
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run(vt[v].s, vt[v].d, vt[v].n, vt[v].lat, vt[v].intr, vt[v].nm);
            if (v == 0)
                chk("T2 dst bytes", {mem[40], mem[41], mem[42], mem[43]},
                    {f(8'h11), f(8'h22), f(8'h33), f(8'h44)});
        end

        for (int r = 0; r < 12; r++) begin
            s = 32'($urandom_range(0, 120));
            d = 32'($urandom_range(0, 200));
            n = $urandom_range(1, 20);
            if (d > s && d < s + 32'(n)) d = s;
            run(s, d, n, 2 * n + 2, 0, "random");
        end

        // Abort during the write cycle of byte 2; bytes 0-1 must land, byte 2 must not.
        for (int i = 0; i < 256; i++) im[i] = 8'h5A;
        im[24] = 8'h11; im[25] = 8'h22; im[26] = 8'h33; im[27] = 8'h44;
        load_mem(im);
        @(negedge clk);
        start = 1'b1; src_base = 32'd24; dst_base = 32'd40; len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("T1 in WR", 64'(mem_we_n), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("T1 we_n after rst", 64'(mem_we_n), 64'(1));
        chk("T1 busy after rst", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("T1 bytes 0-1", {mem[40], mem[41]}, {f(8'h11), f(8'h22)});
        chk("T1 bytes 2-3", {mem[42], mem[43]}, {8'h5A, 8'h5A});
        chk("T1 idle a/b", {mem_a, mem_b}, 64'(0));
        run(32'd24, 32'd40, 4, 10, 0, "after reset");

        chk("we_n low twice", 64'(we_pair), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
